// File: rtl/adpll_loop_filter.sv
// adpll_loop_filter
//   Proportional-integral loop filter between the ADPLL phase detector and
//   the DCO. Each accepted phase-error sample updates a saturating integrator
//   (stage 1), then the next cycle produces the saturated DCO control code
//   (err >>> KP_SHIFT) + (acc >>> KI_SHIFT) (stage 2). It also flags lock
//   after LOCK_COUNT consecutive samples with |error| <= LOCK_THRESH.
//
// Ports
//   fpga_clk_i      in   clock for all logic
//   reset_i         in   synchronous active-high reset
//   enable_i        in   low: incoming strobes are dropped
//   clear_i         in   synchronous clear of integrator, pipeline, lock
//   error_i         in   signed phase error [ERR_W]
//   error_valid_i   in   one-cycle strobe qualifying error_i
//   dco_cc_o        out  signed DCO control code [CC_W]
//   dco_cc_valid_o  out  one-cycle pulse when dco_cc_o updates
//   lock_o          out  loop-locked indicator
module adpll_loop_filter #(
    parameter int ERR_W       = 8,
    parameter int CC_W        = 9,
    parameter int ACC_W       = 16,
    parameter int KP_SHIFT    = 1,
    parameter int KI_SHIFT    = 3,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 8
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic signed [ERR_W-1:0] error_i,
    input  logic                    error_valid_i,
    output logic signed [CC_W-1:0]  dco_cc_o,
    output logic                    dco_cc_valid_o,
    output logic                    lock_o
);
    localparam int CNT_W = $clog2(LOCK_COUNT + 1);

    logic signed [ERR_W-1:0] err_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [CC_W-1:0]  cc_q;
    logic [1:0]              vld_pipe;   // [0] stage-1 valid, [1] output valid
    logic [CNT_W-1:0]        cnt;
    logic                    lock_q;

    logic                    accept;
    logic [ACC_W:0]          acc_sum;
    logic [ACC_W-1:0]        acc_sat;
    logic signed [ERR_W-1:0] err_sh;
    logic signed [ACC_W-1:0] acc_sh;
    logic [ACC_W:0]          cc_sum;
    logic [ACC_W:CC_W-1]     cc_hi;
    logic [CC_W-1:0]         cc_sat;
    logic [ERR_W:0]          err_ext;
    logic [ERR_W:0]          mag;
    logic                    in_thr;
    logic [CNT_W-1:0]        cnt_nxt;

    assign accept = error_valid_i & enable_i & ~clear_i;

    always_comb begin
        // Integrator: one guard bit; overflow when the two top bits disagree,
        // then clamp toward the sign of the true sum.
        acc_sum = {acc[ACC_W-1], acc}
                + {{(ACC_W + 1 - ERR_W){error_i[ERR_W-1]}}, error_i};
        acc_sat = acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
            acc_sat = {acc_sum[ACC_W], {(ACC_W - 1){~acc_sum[ACC_W]}}};

        // Output code: fits CC_W only if all bits above the CC sign agree.
        err_sh = err_q >>> KP_SHIFT;
        acc_sh = acc >>> KI_SHIFT;
        cc_sum = {{(ACC_W + 1 - ERR_W){err_sh[ERR_W-1]}}, err_sh}
               + {acc_sh[ACC_W-1], acc_sh};
        cc_hi  = cc_sum[ACC_W:CC_W-1];
        cc_sat = cc_sum[CC_W-1:0];
        if (!((&cc_hi) || !(|cc_hi)))
            cc_sat = {cc_sum[ACC_W], {(CC_W - 1){~cc_sum[ACC_W]}}};

        // |error| in ERR_W+1 bits so the most negative code has a magnitude.
        err_ext = {error_i[ERR_W-1], error_i};
        mag     = err_ext[ERR_W] ? (~err_ext + 1'b1) : err_ext;
        in_thr  = (mag <= (ERR_W + 1)'(LOCK_THRESH));
        cnt_nxt = '0;
        if (in_thr)
            cnt_nxt = (cnt == CNT_W'(LOCK_COUNT)) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i || clear_i) begin
            err_q    <= '0;
            acc      <= '0;
            cc_q     <= '0;
            vld_pipe <= '0;
            cnt      <= '0;
            lock_q   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], accept};
            // Stage 2 reads acc already updated by this sample's stage 1.
            if (vld_pipe[0])
                cc_q <= cc_sat;
            if (accept) begin
                err_q  <= error_i;
                acc    <= acc_sat;
                cnt    <= cnt_nxt;
                lock_q <= (cnt_nxt == CNT_W'(LOCK_COUNT));
            end
        end
    end

    assign dco_cc_o       = cc_q;
    assign dco_cc_valid_o = vld_pipe[1];
    assign lock_o         = lock_q;
endmodule

// File: tb/tb_adpll_loop_filter.sv
module tb_adpll_loop_filter;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              clr = 1'b0;
    logic signed [7:0] err = '0;
    logic              ev  = 1'b0;
    logic signed [8:0] cc;
    logic              cc_v;
    logic              lock;

    int n_tests = 0;
    int n_fail  = 0;

    adpll_loop_filter dut (
        .fpga_clk_i    (clk),
        .reset_i       (rst),
        .enable_i      (en),
        .clear_i       (clr),
        .error_i       (err),
        .error_valid_i (ev),
        .dco_cc_o      (cc),
        .dco_cc_valid_o(cc_v),
        .lock_o        (lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: plain integers, a pending-sample slot for the
    // two-cycle latency, clamping by min/max.
    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    int m_acc = 0, m_cc = 0, m_cnt = 0;
    bit m_valid = 0, m_lock = 0, pend = 0, live = 0;
    int pend_err = 0;

    always @(posedge clk) begin
        int e, mag;
        if (rst || clr) begin
            m_acc = 0; m_cc = 0; m_cnt = 0; m_valid = 0; m_lock = 0; pend = 0;
            if (rst) live = 1;
        end else begin
            // output from the previously accepted sample, using its acc
            m_valid = pend;
            if (pend)
                m_cc = clamp((pend_err >>> 1) + (m_acc >>> 3), -256, 255);
            pend = ev && en;
            if (pend) begin
                e        = int'(err);
                pend_err = e;
                m_acc    = clamp(m_acc + e, -32768, 32767);
                mag      = (e < 0) ? -e : e;
                m_cnt    = (mag <= 2) ? ((m_cnt < 8) ? m_cnt + 1 : 8) : 0;
                m_lock   = (m_cnt == 8);
            end
        end
        #1;
        if (live) begin
            chk("cc_model",    int'(cc), m_cc);
            chk("valid_model", int'(cc_v), int'(m_valid));
            chk("lock_model",  int'(lock), int'(m_lock));
            chk("acc_model",   int'(dut.acc), m_acc);
        end
    end

    // Drive inputs on the falling edge; the following rising edge samples them.
    task automatic put(input int e, input bit v, input bit ena = 1'b1,
                       input bit c = 1'b0, input bit r = 1'b0);
        @(negedge clk);
        err = 8'(e); ev = v; en = ena; clr = c; rst = r;
    endtask

    task automatic idle();
        put(0, 1'b0);
    endtask

    task automatic do_clear();
        put(0, 1'b0, 1'b1, 1'b1);
        idle();
    endtask

    initial begin
        repeat (3) put(0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("reset_cc", int'(cc), 0);
        chk("reset_valid", int'(cc_v), 0);
        chk("reset_lock", int'(lock), 0);
        chk("reset_acc", int'(dut.acc), 0);

        // 1: single +16 sample -> acc 16, then cc = 8 + 2 = 10 for one cycle
        put(16, 1'b1);
        idle();
        chk("t1_acc", int'(dut.acc), 16);
        chk("t1_valid_n1", int'(cc_v), 0);
        idle();
        chk("t1_cc", int'(cc), 10);
        chk("t1_valid_n2", int'(cc_v), 1);
        idle();
        chk("t1_valid_n3", int'(cc_v), 0);
        chk("t1_cc_hold", int'(cc), 10);

        // 2: +127 every cycle saturates both acc and cc
        do_clear();
        for (int i = 0; i < 300; i++) put(127, 1'b1);
        idle(); idle();
        chk("t2_acc_sat", int'(dut.acc), 32767);
        chk("t2_cc_sat", int'(cc), 255);

        // 3: -128 every cycle saturates negative, never locks
        do_clear();
        for (int i = 0; i < 300; i++) begin
            put(-128, 1'b1);
            if (lock) chk("t3_lock", int'(lock), 0);
        end
        idle(); idle();
        chk("t3_acc_sat", int'(dut.acc), -32768);
        chk("t3_cc_sat", int'(cc), -256);
        chk("t3_lock_end", int'(lock), 0);

        // 4: eight +1 samples lock; a +3 sample drops lock
        do_clear();
        for (int i = 0; i < 8; i++) put(1, 1'b1);
        chk("t4_lock_after7", int'(lock), 0);
        put(3, 1'b1);
        chk("t4_lock_after8", int'(lock), 1);
        idle();
        chk("t4_unlock", int'(lock), 0);

        // 5: clear beats a simultaneous strobe with acc = 200
        do_clear();
        put(100, 1'b1); put(100, 1'b1);
        repeat (3) idle();
        chk("t5_acc_pre", int'(dut.acc), 200);
        put(50, 1'b1, 1'b1, 1'b1);
        idle();
        chk("t5_acc", int'(dut.acc), 0);
        chk("t5_cc", int'(cc), 0);
        chk("t5_lock", int'(lock), 0);
        chk("t5_valid_n1", int'(cc_v), 0);
        idle();
        chk("t5_valid_n2", int'(cc_v), 0);

        // 6a: enable falls with one sample in flight -> exactly one pulse
        do_clear();
        put(20, 1'b1);
        put(20, 1'b1, 1'b0);
        chk("t6_acc", int'(dut.acc), 20);
        put(20, 1'b1, 1'b0);
        chk("t6_inflight_valid", int'(cc_v), 1);
        chk("t6_inflight_cc", int'(cc), 12);
        for (int i = 0; i < 5; i++) begin
            put(20, 1'b1, 1'b0);
            chk("t6_no_pulse", int'(cc_v), 0);
        end
        chk("t6_acc_hold", int'(dut.acc), 20);

        // 6b: reset at N+1 discards the in-flight sample
        do_clear();
        put(20, 1'b1);
        put(0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("t6r_valid", int'(cc_v), 0);
        chk("t6r_cc", int'(cc), 0);
        chk("t6r_lock", int'(lock), 0);
        chk("t6r_acc", int'(dut.acc), 0);
        idle();
        chk("t6r_valid2", int'(cc_v), 0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int e;
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                            : int'($urandom_range(0, 6)) - 3;
            put(e, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
        end
        idle(); idle(); idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
